// File: rtl/clk_gate_sched_pkg.sv
// Shared types, default constants and the round-robin picker for clk_gate_sched.
package clk_gate_sched_pkg;

  localparam int unsigned CG_IDLE_CYC = 16;
  localparam int unsigned CG_WAKE_CYC = 2;
  localparam int unsigned CG_CW       = 8;
  localparam int unsigned CG_MAX_DOM  = 16;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    WAKING = 2'd1,
    ON     = 2'd2,
    DRAIN  = 2'd3
  } cg_state_t;

  // Unused upper request bits are zero, so a mod-16 search
  // visits the live domains in the same order as mod N_DOM.
  function automatic logic [CG_MAX_DOM-1:0] rr_pick(
    input logic [CG_MAX_DOM-1:0] req,
    input logic [3:0]            ptr
  );
    logic [CG_MAX_DOM-1:0] gnt;
    logic                  found;
    logic [3:0]            idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < CG_MAX_DOM; k++) begin
      idx = ptr + 4'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/cg_dom_fsm.sv
// Per-domain OFF/WAKING/ON/DRAIN controller with a shared wake/idle counter.
module cg_dom_fsm
  import clk_gate_sched_pkg::*;
#(
  parameter int unsigned IDLE_CYC = CG_IDLE_CYC,
  parameter int unsigned WAKE_CYC = CG_WAKE_CYC,
  parameter int unsigned CW       = CG_CW
) (
  input  logic clk,
  input  logic reset,
  input  logic need,
  input  logic grant,
  output logic gate_en,
  output logic wake_ack,
  output logic is_off,
  output logic is_waking,
  output logic wake_last
);

  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC);
  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC);
  localparam logic [CW-1:0] ONE     = CW'(1);

  cg_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_dec;
  logic          gate_q, gate_d;
  logic          ack_q, ack_d;
  logic          cnt_last;

  assign cnt_dec  = (cnt_q != '0) ? cnt_q - ONE : cnt_q;
  assign cnt_last = (cnt_q <= ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (grant) begin
          state_d = WAKING;
          cnt_d   = WAKE_LD;
        end
      end
      WAKING: begin
        if (cnt_last) begin
          state_d = ON;
          cnt_d   = IDLE_LD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ON: begin
        if (need) begin
          cnt_d = IDLE_LD;
        end else if (cnt_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      DRAIN: begin
        if (need) begin
          state_d = ON;
          cnt_d   = IDLE_LD;
        end else begin
          state_d = OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
    gate_d = (state_d != OFF);
    ack_d  = (state_d == ON);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      ack_q   <= ack_d;
    end
  end

  assign gate_en   = gate_q;
  assign wake_ack  = ack_q;
  assign is_off    = (state_q == OFF);
  assign is_waking = (state_q == WAKING);
  // A domain in its final WAKING cycle hands the inrush slot on.
  assign wake_last = is_waking && cnt_last;

endmodule

// File: rtl/clk_gate_sched.sv
// Gated-clock enable scheduler with round-robin single-domain wake.
// Optional per-domain wake counters: CLK_GATE_SCHED_STATS_EN.
module clk_gate_sched
  import clk_gate_sched_pkg::*;
#(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned IDLE_CYC = CG_IDLE_CYC,
  parameter int unsigned WAKE_CYC = CG_WAKE_CYC,
  parameter int unsigned CW       = CG_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DOM-1:0] dom_busy,
  input  logic [N_DOM-1:0] wake_req,
  input  logic             force_on,
  output logic [N_DOM-1:0] gate_en,
  output logic [N_DOM-1:0] wake_ack,
`ifdef CLK_GATE_SCHED_STATS_EN
  output logic [N_DOM*CW-1:0] wake_cnt,
`endif
  output logic             waking
);

  logic [N_DOM-1:0]      need;
  logic [N_DOM-1:0]      is_off;
  logic [N_DOM-1:0]      is_waking;
  logic [N_DOM-1:0]      wake_last;
  logic [N_DOM-1:0]      grant;
  logic [CG_MAX_DOM-1:0] req_w;
  logic [CG_MAX_DOM-1:0] pick;
  logic [3:0]            ptr_q, ptr_d;
  logic                  busy_slot;

  assign need      = dom_busy | wake_req | {N_DOM{force_on}};
  assign busy_slot = |(is_waking & ~wake_last);

  always_comb begin
    req_w = '0;
    if (!busy_slot) begin
      req_w[N_DOM-1:0] = is_off & need;
    end
    pick  = rr_pick(req_w, ptr_q);
    grant = pick[N_DOM-1:0];
    ptr_d = ptr_q;
    for (int i = 0; i < CG_MAX_DOM; i++) begin
      if (pick[i]) begin
        ptr_d = (i + 1 >= N_DOM) ? 4'd0 : 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar g = 0; g < N_DOM; g++) begin : g_dom
    cg_dom_fsm #(
      .IDLE_CYC (IDLE_CYC),
      .WAKE_CYC (WAKE_CYC),
      .CW       (CW)
    ) u_dom (
      .clk       (clk),
      .reset     (reset),
      .need      (need[g]),
      .grant     (grant[g]),
      .gate_en   (gate_en[g]),
      .wake_ack  (wake_ack[g]),
      .is_off    (is_off[g]),
      .is_waking (is_waking[g]),
      .wake_last (wake_last[g])
    );
  end

  assign waking = |is_waking;

`ifdef CLK_GATE_SCHED_STATS_EN
  logic [CW-1:0] cnt_q [N_DOM];
  logic [CW-1:0] cnt_d [N_DOM];

  always_comb begin
    for (int i = 0; i < N_DOM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DOM; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_DOM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < N_DOM; g++) begin : g_stat
    assign wake_cnt[g*CW +: CW] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_clk_gate_sched.sv
// Randomized and directed bench for clk_gate_sched against a timestamp model.
module tb_clk_gate_sched;

  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int WAKE = 2;
  localparam int M_OFF = 0, M_WAK = 1, M_ON = 2, M_DR = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] dom_busy, wake_req;
  logic         force_on;
  logic [N-1:0] gate_en, wake_ack;
  logic         waking;
`ifdef CLK_GATE_SCHED_STATS_EN
  logic [N*8-1:0] wake_cnt;
  int             m_cnt [N];
`endif

  int checks = 0;
  int errors = 0;

  int mst    [N];
  int t_done [N];
  int t_last [N];
  int mptr;
  int cyc;

  always #5 clk = ~clk;

  clk_gate_sched dut (
    .clk      (clk),
    .reset    (reset),
    .dom_busy (dom_busy),
    .wake_req (wake_req),
    .force_on (force_on),
    .gate_en  (gate_en),
    .wake_ack (wake_ack),
`ifdef CLK_GATE_SCHED_STATS_EN
    .wake_cnt (wake_cnt),
`endif
    .waking   (waking)
  );

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mst[i] = M_OFF;
      t_done[i] = 0;
      t_last[i] = 0;
`ifdef CLK_GATE_SCHED_STATS_EN
      m_cnt[i] = 0;
`endif
    end
    mptr = 0;
    cyc  = 0;
  endfunction

  // Timestamp view: a domain is ON until IDLE edges pass with no need,
  // and the wake slot frees on the edge the waking domain completes.
  function automatic void model_edge(input logic [N-1:0] n);
    int  nst [N];
    bit  blocked;
    bit  found;
    int  j;
    blocked = 0;
    for (int i = 0; i < N; i++) begin
      nst[i] = mst[i];
      if (mst[i] == M_WAK && t_done[i] != cyc) blocked = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (mst[i] == M_WAK && cyc == t_done[i]) begin
        nst[i] = M_ON;
        t_last[i] = cyc;
      end else if (mst[i] == M_ON) begin
        if (n[i]) t_last[i] = cyc;
        else if (cyc >= t_last[i] + IDLE) nst[i] = M_DR;
      end else if (mst[i] == M_DR) begin
        if (n[i]) begin
          nst[i] = M_ON;
          t_last[i] = cyc;
        end else begin
          nst[i] = M_OFF;
        end
      end
    end
    found = 0;
    if (!blocked) begin
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (!found && mst[j] == M_OFF && n[j]) begin
          found = 1;
          nst[j] = M_WAK;
          t_done[j] = cyc + WAKE;
          mptr = (j + 1) % N;
`ifdef CLK_GATE_SCHED_STATS_EN
          if (m_cnt[j] < 255) m_cnt[j]++;
`endif
        end
      end
    end
    for (int i = 0; i < N; i++) mst[i] = nst[i];
  endfunction

  function automatic logic [2*N:0] mexp();
    logic [N-1:0] g, a;
    logic         w;
    w = 1'b0;
    for (int i = 0; i < N; i++) begin
      g[i] = (mst[i] != M_OFF);
      a[i] = (mst[i] == M_ON);
      if (mst[i] == M_WAK) w = 1'b1;
    end
    return {g, a, w};
  endfunction

  task automatic tick();
    logic [N-1:0] n;
    n = dom_busy | wake_req | {N{force_on}};
    @(posedge clk);
    cyc++;
    model_edge(n);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    dom_busy = '0;
    wake_req = '0;
    force_on = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    dom_busy = '1;
    wake_req = '1;
    force_on = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gate_en, wake_ack, waking} !== '0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0", {gate_en, wake_ack, waking});
    end
    do_reset();
  endtask

  task automatic test_single_wake();
    do_reset();
    wake_req[2] = 1'b1;
    tick();
    checks++;
    if ({gate_en[2], wake_ack[2]} !== 2'b10) begin
      errors++;
      $display("FAIL single_gate got %b exp 10", {gate_en[2], wake_ack[2]});
    end
    tick();
    tick();
    checks++;
    if (wake_ack[2] !== 1'b1) begin
      errors++;
      $display("FAIL single_ack got %b exp 1", wake_ack[2]);
    end
    tick();
    wake_req[2] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if ({gate_en, wake_ack, waking} !== mexp()) begin
        errors++;
        $display("FAIL single_model t=%0d got %h exp %h", cyc, {gate_en, wake_ack, waking}, mexp());
      end
      if (k == 16) begin
        checks++;
        if ({gate_en[2], wake_ack[2]} !== 2'b10) begin
          errors++;
          $display("FAIL single_drain got %b exp 10", {gate_en[2], wake_ack[2]});
        end
      end
    end
    checks++;
    if (gate_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL single_off got %b exp 0", gate_en[2]);
    end
  endtask

  task automatic test_inrush();
    logic [N-1:0] eg;
    do_reset();
    dom_busy = '1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (waking !== (k <= 8)) begin
        errors++;
        $display("FAIL inrush_waking k=%0d got %b exp %b", k, waking, (k <= 8));
      end
      if (k % 2 == 1 && k <= 7) begin
        eg = N'((1 << ((k + 1) / 2)) - 1);
        checks++;
        if (gate_en !== eg) begin
          errors++;
          $display("FAIL inrush_gate k=%0d got %b exp %b", k, gate_en, eg);
        end
      end
      checks++;
      if ({gate_en, wake_ack, waking} !== mexp()) begin
        errors++;
        $display("FAIL inrush_model t=%0d got %h exp %h", cyc, {gate_en, wake_ack, waking}, mexp());
      end
    end
    dom_busy = '0;
    repeat (20) tick();
  endtask

  task automatic test_drain_recovery();
    do_reset();
    dom_busy[1] = 1'b1;
    repeat (4) tick();
    dom_busy[1] = 1'b0;
    repeat (16) tick();
    checks++;
    if ({gate_en[1], wake_ack[1]} !== 2'b10) begin
      errors++;
      $display("FAIL drain_state got %b exp 10", {gate_en[1], wake_ack[1]});
    end
    dom_busy[1] = 1'b1;
    tick();
    dom_busy[1] = 1'b0;
    checks++;
    if ({gate_en[1], wake_ack[1]} !== 2'b11) begin
      errors++;
      $display("FAIL drain_back got %b exp 11", {gate_en[1], wake_ack[1]});
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 15) begin
        checks++;
        if ({gate_en[1], wake_ack[1]} !== 2'b11) begin
          errors++;
          $display("FAIL drain_hold k=%0d got %b exp 11", k, {gate_en[1], wake_ack[1]});
        end
      end
      checks++;
      if ({gate_en, wake_ack, waking} !== mexp()) begin
        errors++;
        $display("FAIL drain_model t=%0d got %h exp %h", cyc, {gate_en, wake_ack, waking}, mexp());
      end
    end
  endtask

  task automatic test_force_on();
    do_reset();
    force_on = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if ({gate_en, wake_ack, waking} !== mexp()) begin
        errors++;
        $display("FAIL force_model t=%0d got %h exp %h", cyc, {gate_en, wake_ack, waking}, mexp());
      end
    end
    checks++;
    if (wake_ack !== '1) begin
      errors++;
      $display("FAIL force_all_on got %b exp 1111", wake_ack);
    end
    force_on = 1'b0;
    for (int k = 1; k <= IDLE + 1; k++) begin
      tick();
      if (k == IDLE) begin
        checks++;
        if (gate_en !== '1) begin
          errors++;
          $display("FAIL force_drain got %b exp 1111", gate_en);
        end
      end
    end
    checks++;
    if (gate_en !== '0) begin
      errors++;
      $display("FAIL force_off got %b exp 0000", gate_en);
    end
  endtask

  task automatic test_reset_mid_wake();
    do_reset();
    wake_req[3] = 1'b1;
    tick();
    checks++;
    if ({gate_en[3], waking} !== 2'b11) begin
      errors++;
      $display("FAIL midwake_start got %b exp 11", {gate_en[3], waking});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gate_en, wake_ack, waking} !== '0) begin
      errors++;
      $display("FAIL midwake_async got %h exp 0", {gate_en, wake_ack, waking});
    end
    wake_req = '0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    wake_req = 4'b0010;
    tick();
    #2 reset = 1'b1;
    wake_req = '0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    wake_req = 4'b0101;
    tick();
    checks++;
    if (gate_en !== 4'b0001) begin
      errors++;
      $display("FAIL midwake_ptr got %b exp 0001", gate_en);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({gate_en, wake_ack, waking} !== mexp()) begin
        errors++;
        $display("FAIL midwake_model t=%0d got %h exp %h", cyc, {gate_en, wake_ack, waking}, mexp());
      end
    end
    wake_req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) dom_busy[i] = ~dom_busy[i];
        if (!wake_req[i] && $urandom_range(0, 29) == 0) wake_req[i] = 1'b1;
        else if (wake_req[i] && wake_ack[i]) wake_req[i] = 1'b0;
      end
      if (!force_on && $urandom_range(0, 149) == 0) force_on = 1'b1;
      else if (force_on && $urandom_range(0, 7) == 0) force_on = 1'b0;
      tick();
      checks++;
      if ({gate_en, wake_ack, waking} !== mexp()) begin
        errors++;
        $display("FAIL rand_model t=%0d got %h exp %h", cyc, {gate_en, wake_ack, waking}, mexp());
      end
`ifdef CLK_GATE_SCHED_STATS_EN
      for (int i = 0; i < N; i++) begin
        checks++;
        if (wake_cnt[i*8 +: 8] !== 8'(m_cnt[i])) begin
          errors++;
          $display("FAIL rand_stats d=%0d got %0d exp %0d", i, wake_cnt[i*8 +: 8], m_cnt[i]);
        end
      end
`endif
    end
    dom_busy = '0;
    wake_req = '0;
    force_on = 1'b0;
  endtask

`ifdef CLK_GATE_SCHED_STATS_EN
  task automatic test_stats();
    int w;
    do_reset();
    for (int r = 0; r < 300; r++) begin
      wake_req[0] = 1'b1;
      w = 0;
      while (wake_ack[0] !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      wake_req[0] = 1'b0;
      w = 0;
      while (gate_en[0] !== 1'b0 && w < 30) begin
        tick();
        w++;
      end
      if (w >= 30) begin
        checks++;
        errors++;
        $display("FAIL stats_timeout r=%0d", r);
      end
    end
    checks++;
    if (wake_cnt[7:0] !== 8'd255 || m_cnt[0] != 255) begin
      errors++;
      $display("FAIL stats_sat got %0d exp 255", wake_cnt[7:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_wake();
    test_inrush();
    test_drain_recovery();
    test_force_on();
    test_reset_mid_wake();
    test_random();
`ifdef CLK_GATE_SCHED_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
